// File: rtl/fp16_accum.sv
// fp16_accum: sums LEN IEEE binary16 products per window, three cycles per accepted input.
// Optional macro FP16_ACCUM_BIAS_EN adds a bias input that seeds the accumulator at window start.
module fp16_accum #(
    parameter int unsigned LEN = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
`ifdef FP16_ACCUM_BIAS_EN
    input  logic [15:0] bias,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    typedef enum logic [2:0] {IDLE, ACC, ALIGN, NORM, DONE} state_t;

    localparam logic [9:0] LEN_CNT = LEN[9:0];

    state_t      state, state_nx;
    logic        armed;
    logic [9:0]  count;
    logic [15:0] acc;
    logic [15:0] operand;
    logic [15:0] start_val;

    // ALIGN stage results
    logic [4:0]  exp_big;
    logic [10:0] sig_big, sig_small;
    logic        sign_big, sign_small;
    logic        special;
    logic [15:0] special_val;

`ifdef FP16_ACCUM_BIAS_EN
    assign start_val = bias;
`else
    assign start_val = '0;
`endif

    // Alignment of accumulator against the captured operand
    logic        a_nan, a_inf, b_nan, b_inf, a_big;
    logic [14:0] key_a, key_b;
    logic [10:0] sig_a, sig_b, sig_l, sig_s, sig_s_aligned;
    logic [4:0]  exp_l, exp_s, exp_diff;
    logic        sign_l, sign_s;
    logic        special_c;
    logic [15:0] special_val_c;

    always_comb begin
        a_nan = (&acc[14:10]) & (|acc[9:0]);
        a_inf = (&acc[14:10]) & ~(|acc[9:0]);
        b_nan = (&operand[14:10]) & (|operand[9:0]);
        b_inf = (&operand[14:10]) & ~(|operand[9:0]);
        // Subnormals carry a zero key and zero significand, so they behave as zero
        key_a = (acc[14:10] == 5'd0) ? '0 : acc[14:0];
        key_b = (operand[14:10] == 5'd0) ? '0 : operand[14:0];
        sig_a = (acc[14:10] == 5'd0) ? '0 : {1'b1, acc[9:0]};
        sig_b = (operand[14:10] == 5'd0) ? '0 : {1'b1, operand[9:0]};
        a_big  = key_a >= key_b;
        exp_l  = a_big ? key_a[14:10] : key_b[14:10];
        exp_s  = a_big ? key_b[14:10] : key_a[14:10];
        sig_l  = a_big ? sig_a : sig_b;
        sig_s  = a_big ? sig_b : sig_a;
        sign_l = a_big ? acc[15] : operand[15];
        sign_s = a_big ? operand[15] : acc[15];
        exp_diff = exp_l - exp_s;
        sig_s_aligned = (exp_diff >= 5'd12) ? '0 : (sig_s >> exp_diff);

        special_c     = 1'b1;
        special_val_c = 16'h7E00;
        if (a_nan | b_nan | (a_inf & b_inf & (acc[15] ^ operand[15])))
            special_val_c = 16'h7E00;
        else if (a_inf)
            special_val_c = {acc[15], 15'h7C00};
        else if (b_inf)
            special_val_c = {operand[15], 15'h7C00};
        else
            special_c = 1'b0;
    end

    // Add/subtract, leading-zero normalise, truncate
    logic [11:0]       raw;
    logic [3:0]        lz;
    logic [9:0]        shifted, mant;
    logic signed [6:0] exp_res;
    logic [15:0]       sum_val;

    always_comb begin
        if (sign_big == sign_small)
            raw = {1'b0, sig_big} + {1'b0, sig_small};
        else
            raw = {1'b0, sig_big} - {1'b0, sig_small};
        lz = '0;
        for (int unsigned i = 0; i < 11; i++)
            if (raw[i]) lz = 4'(10 - i);
        shifted = raw[9:0] << lz;
        if (raw[11]) begin
            exp_res = $signed({2'b00, exp_big}) + 7'sd1;
            mant    = raw[10:1];
        end else begin
            exp_res = $signed({2'b00, exp_big}) - $signed({3'b000, lz});
            mant    = shifted;
        end
        if (raw == 12'd0 || exp_res <= 7'sd0)
            sum_val = '0;
        else if (exp_res > 7'sd30)
            sum_val = {sign_big, 15'h7C00};
        else
            sum_val = {sign_big, exp_res[4:0], mant};
    end

    // armed delays the first IDLE->ACC step by one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (state)
            IDLE:  if (armed) state_nx = ACC;
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ALIGN;
            end
            ALIGN: state_nx = NORM;
            NORM:  state_nx = (count + 10'd1 == LEN_CNT) ? DONE : ACC;
            DONE: begin
                out_valid = 1'b1;
                out_data  = acc;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            count       <= '0;
            operand     <= '0;
            exp_big     <= '0;
            sig_big     <= '0;
            sig_small   <= '0;
            sign_big    <= 1'b0;
            sign_small  <= 1'b0;
            special     <= 1'b0;
            special_val <= '0;
        end else begin
            case (state)
                IDLE: begin
                    acc   <= start_val;
                    count <= '0;
                end
                ACC: if (in_valid) operand <= in_data;
                ALIGN: begin
                    exp_big     <= exp_l;
                    sig_big     <= sig_l;
                    sig_small   <= sig_s_aligned;
                    sign_big    <= sign_l;
                    sign_small  <= sign_s;
                    special     <= special_c;
                    special_val <= special_val_c;
                end
                NORM: begin
                    acc   <= special ? special_val : sum_val;
                    count <= count + 10'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accum.sv
// Self-checking bench for fp16_accum: directed windows plus randomized traffic against a value-level model.
module tb_fp16_accum;

`ifdef FP16_ACCUM_BIAS_EN
    localparam logic [15:0] BIAS_VAL = 16'h4000;
    localparam logic [15:0] EXP_ONES = 16'h4980;
    localparam logic [15:0] EXP_ALT  = 16'h4200;
    localparam logic [15:0] EXP_C2   = 16'h4000;
    localparam logic [15:0] EXP_P2   = 16'h4400;
`else
    localparam logic [15:0] BIAS_VAL = 16'h0000;
    localparam logic [15:0] EXP_ONES = 16'h4880;
    localparam logic [15:0] EXP_ALT  = 16'h3C00;
    localparam logic [15:0] EXP_C2   = 16'h0000;
    localparam logic [15:0] EXP_P2   = 16'h4000;
`endif
    localparam int LEN = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [15:0] out_data;
    logic [15:0] bias_sig = BIAS_VAL;

    logic        v2 = 1'b0;
    logic [15:0] d2 = '0;
    logic        or2 = 1'b1;
    logic        rdy2, ov2;
    logic [15:0] od2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    fp16_accum #(.LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef FP16_ACCUM_BIAS_EN
        .bias(bias_sig),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    fp16_accum #(.LEN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
`ifdef FP16_ACCUM_BIAS_EN
        .bias(bias_sig),
`endif
        .out_valid(ov2), .out_ready(or2), .out_data(od2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Value-level reference: align the smaller magnitude by truncation, add, renormalise.
    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, el, es, ml, ms, sh, r, e;
        logic sa, sb, sl, ss;
        logic an, bn, ai, bi;
        an = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        bn = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        ai = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        bi = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        if (an || bn || (ai && bi && a[15] != b[15])) return 16'h7E00;
        if (ai) return {a[15], 15'h7C00};
        if (bi) return {b[15], 15'h7C00};
        ea = a[14:10]; eb = b[14:10]; sa = a[15]; sb = b[15];
        ma = (ea == 0) ? 0 : 1024 + a[9:0];
        mb = (eb == 0) ? 0 : 1024 + b[9:0];
        if (ma == 0 && mb == 0) return 16'h0000;
        if (ea > eb || (ea == eb && ma >= mb)) begin
            el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb;
        end else begin
            el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa;
        end
        sh = el - es;
        ms = (sh >= 12) ? 0 : (ms >> sh);
        r = (sl == ss) ? ml + ms : ml - ms;
        if (r == 0) return 16'h0000;
        e = el;
        while (r >= 2048) begin r = r / 2; e++; end
        while (r < 1024)  begin r = r * 2; e--; end
        if (e <= 0) return 16'h0000;
        if (e > 30) return {sl, 15'h7C00};
        return {sl, e[4:0], r[9:0]};
    endfunction

    function automatic logic [15:0] rand_fp();
        int unsigned k;
        logic s;
        k = $urandom_range(0, 99);
        s = 1'($urandom_range(0, 1));
        if (k < 2)  return {s, 15'h7C00};
        if (k < 4)  return {1'b0, 5'h1F, 10'($urandom_range(1, 1023))};
        if (k < 8)  return {s, 5'h00, 10'($urandom)};
        if (k < 11) return {s, 15'h0000};
        if (k < 16) return {s, 5'($urandom_range(28, 30)), 10'($urandom)};
        return {s, 5'($urandom_range(8, 20)), 10'($urandom)};
    endfunction

    // Cycle-level expectations derived from the 3-cycles-per-input and handshake rules
    logic [15:0] m_acc, m_res;
    int   m_n = 0;
    logic pending = 1'b0;
    logic in_rst = 1'b1;
    int   ready_cyc = 0;
    int   valid_cyc = 0;
    logic exp_ready, exp_valid;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset in_ready", {15'b0, in_ready}, 16'h0);
            check("reset out_valid", {15'b0, out_valid}, 16'h0);
            check("reset out_data", out_data, 16'h0000);
            m_acc = BIAS_VAL; m_n = 0; pending = 1'b0; in_rst = 1'b1;
        end else begin
            if (in_rst) begin
                ready_cyc = cyc + 2;
                in_rst = 1'b0;
            end
            exp_ready = !pending && (cyc >= ready_cyc);
            exp_valid = pending && (cyc >= valid_cyc);
            check("in_ready", {15'b0, in_ready}, {15'b0, exp_ready});
            check("out_valid", {15'b0, out_valid}, {15'b0, exp_valid});
            if (out_valid && exp_valid) check("out_data", out_data, m_res);
            if (exp_ready && in_valid) begin
                m_acc = model_add(m_acc, in_data);
                m_n++;
                if (m_n == LEN) begin
                    pending = 1'b1; m_res = m_acc; valid_cyc = cyc + 3;
                    m_acc = BIAS_VAL; m_n = 0;
                end else begin
                    ready_cyc = cyc + 3;
                end
            end
            if (exp_valid && out_ready) begin
                pending = 1'b0;
                ready_cyc = cyc + 2;
            end
        end
    end

    int last_xfer = 0;

    task automatic send(input logic [15:0] d);
        in_valid = 1'b1;
        in_data = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                last_xfer = cyc;
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_data = 16'($urandom);
                return;
            end
        end
        check("send timeout", 16'h0001, 16'h0000);
        in_valid = 1'b0;
    endtask

    task automatic get_result(output logic [15:0] v, output int vc);
        v = 16'hxxxx; vc = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                v = out_data; vc = cyc;
                @(posedge clk); #1;
                return;
            end
        end
        check("result timeout", 16'h0001, 16'h0000);
        @(posedge clk); #1;
    endtask

    task automatic send2(input logic [15:0] d);
        v2 = 1'b1; d2 = d;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rdy2) begin
                @(posedge clk); #1;
                v2 = 1'b0;
                return;
            end
        end
        check("send2 timeout", 16'h0001, 16'h0000);
        v2 = 1'b0;
    endtask

    task automatic get2(input string name, input logic [15:0] want);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ov2) begin
                check(name, od2, want);
                @(posedge clk); #1;
                return;
            end
        end
        check("len2 timeout", 16'h0001, 16'h0000);
    endtask

    logic [15:0] res;
    int first, vcyc;

    initial begin
        check("model 1+1", model_add(16'h3C00, 16'h3C00), 16'h4000);
        check("model 1-1", model_add(16'h3C00, 16'hBC00), 16'h0000);
        check("model ovf", model_add(16'h7BFF, 16'h7BFF), 16'h7C00);
        check("model inf-inf", model_add(16'h7C00, 16'hFC00), 16'h7E00);
        check("model 8+1", model_add(16'h4800, 16'h3C00), 16'h4880);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < LEN; i++) begin
            send(16'h3C00);
            if (i == 0) first = last_xfer;
        end
        get_result(res, vcyc);
        check("nine ones", res, EXP_ONES);
        check("latency", 16'(vcyc - first), 16'd27);

        for (int i = 0; i < LEN; i++) send((i % 2 == 1) ? 16'hBC00 : 16'h3C00);
        get_result(res, vcyc);
        check("alternating", res, EXP_ALT);

        for (int i = 0; i < LEN; i++) send(16'h7BFF);
        get_result(res, vcyc);
        check("overflow", res, 16'h7C00);

        for (int i = 0; i < LEN; i++) send((i == 3) ? 16'h7E00 : 16'h3C00);
        get_result(res, vcyc);
        check("nan window", res, 16'h7E00);

        out_ready = 1'b0;
        for (int i = 0; i < LEN; i++) send(16'h3C00);
        get_result(res, vcyc);
        in_valid = 1'b1; in_data = 16'h7E00;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall out_valid", {15'b0, out_valid}, 16'h0001);
            check("stall out_data", out_data, EXP_ONES);
            check("stall in_ready", {15'b0, in_ready}, 16'h0000);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < LEN; i++) send(16'h3C00);
        get_result(res, vcyc);
        check("after stall", res, EXP_ONES);

        for (int i = 0; i < 4; i++) send(16'h3C00);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset out_data", out_data, 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < LEN; i++) send(16'h3C00);
        get_result(res, vcyc);
        check("after reset", res, EXP_ONES);

        send2(16'h3C00); send2(16'hBC00);
        get2("len2 cancel", EXP_C2);
        send2(16'h3C00); send2(16'h3C00);
        get2("len2 plus", EXP_P2);

        for (int i = 0; i < 2500; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = rand_fp();
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: got timeout want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
